spi_mem_responder: RTL and testbench
====================================

// Module: spi_mem_responder
// PURPOSE
//  SPI mode-0 slave that emulates the serial program memory: decodes 8-bit command + 16-bit
//  address from the SPI master, then streams 16-bit words MSB-first on IO1 (READ) or captures
//  words from IO0 (WRITE), backed by a synchronous on-chip memory port. Used as the far end of
//  the program-fetch link in simulation and on FPGA builds without external flash.
// PARAMETERS
//  ADDR_W      16     word address width (wraps modulo 2^ADDR_W)
//  DATA_W      16     word width, shifted MSB-first
//  CMD_READ    8'h03  read command, no dummy cycles
//  CMD_WRITE   8'h02  write command
//  SYNC_STAGES 2      synchronizer depth on spi_cs / spi_sclk / spi_io0_i (>=2)
// PORTS
//  clk         in   1       system clock; SCLK period must be >= 8 clk cycles
//  rst         in   1       asynchronous, active-low reset
//  spi_cs      in   1       chip select, active low
//  spi_sclk    in   1       serial clock, idle low (mode 0)
//  spi_io0_i   in   1       MOSI: command, address, write data
//  spi_io1_o   out  1       MISO: read data
//  spi_io1_oe  out  1       MISO output enable
//  mem_addr    out  ADDR_W  memory word address
//  mem_rd_en   out  1       read strobe; mem_rdata valid exactly 1 clk later
//  mem_rdata   in   DATA_W  memory read data
//  mem_wr_en   out  1       write strobe (1-clk pulse)
//  mem_wdata   out  DATA_W  write data, valid with mem_wr_en
//  busy        out  1       high while synchronized CS is low
//  cmd_err     out  1       1-clk pulse when an unknown command byte completes
// BEHAVIOUR
//  - Reset: all outputs 0 (spi_io1_o=0, spi_io1_oe=0, mem_*=0, busy=0, cmd_err=0); state IDLE.
//  - Inputs pass SYNC_STAGES flops; rise/fall of SCLK detected from last two synced samples.
//    Bits sampled on detected SCLK rise; MISO updated on detected SCLK fall. Latency from pin
//    edge to internal event = SYNC_STAGES+1 clk.
//  - Synced CS high in any state: abort to IDLE next clk, spi_io1_oe=0, no memory strobe,
//    partial write word discarded, counters cleared. CS low with SCLK high at entry: first
//    edge counted is the next rise.
//  - States: IDLE -> CMD on CS fall. CMD: 8 rises; byte==CMD_READ -> ADDR(rd),
//    ==CMD_WRITE -> ADDR(wr), else cmd_err pulse -> IGNORE (hold until CS high).
//    ADDR: 16 rises MSB-first into addr reg; then RD_FETCH or WR_DATA.
//  - RD_FETCH: clk after 16th address rise asserts mem_rd_en with mem_addr=addr; next clk loads
//    shift reg, sets spi_io1_oe=1 and spi_io1_o=MSB immediately (not waiting for a fall, since
//    master has no dummy cycle). -> RD_DATA.
//  - RD_DATA: each fall shifts next bit out; after 16 rises the word is done. Prefetch: on the
//    8th rise of each word, mem_rd_en for addr+1 into a holding reg; on the fall following the
//    16th rise, holding reg loads shift reg and its MSB is driven. addr increments per word;
//    0xFFFF -> 0x0000 wrap. Unbounded burst until CS high.
//  - WR_DATA: 16 rises shift IO0 into mem_wdata; 16th rise -> 1-clk mem_wr_en at current addr,
//    then addr+1 (wraps). spi_io1_oe stays 0 throughout WRITE.
//  - mem_rd_en and mem_wr_en never asserted in the same clk; both are single-clk pulses.
//  - busy = synced CS low; reflects pin with SYNC_STAGES clk delay.
// TESTING
//  1 mem[0x0010]=0xA5C3; master CS low, 0x03, 0x0010, 16 clocks at SCLK=clk/8 -> master
//    reads 0xA5C3; exactly one mem_rd_en with mem_addr=0x0010 before first data rise.
//  2 Burst: READ 0xFFFF, 48 data clocks, mem[0xFFFF]=0x1111, [0]=0x2222, [1]=0x3333 ->
//    words 0x1111,0x2222,0x3333 back-to-back, no gap bits; mem_rd_en at 0xFFFF,0x0000,0x0001.
//  3 WRITE 0x0200, data 0xBEEF,0x1234 -> mem_wr_en pulses (0x0200,0xBEEF),(0x0201,0x1234);
//    spi_io1_oe=0 whole transaction.
//  4 Command 0x9F -> one cmd_err pulse after 8th rise; no mem strobes; MISO hi-Z until CS
//    high; next transaction READ 0x0000 works normally.
//  5 CS high after 10 bits of a write word, and separately mid address -> no mem_wr_en,
//    return to IDLE, oe=0; following READ returns correct data.
//  6 Assert rst low mid read burst -> all outputs 0 asynchronously; after release, CS toggle
//    and READ 0x0010 returns 0xA5C3.

Source files
------------

// File: rtl/spi_mem_responder.sv
// spi_mem_responder
//   SPI mode-0 slave standing in for the serial program memory. The master
//   sends an 8-bit command and a 16-bit word address MSB-first on IO0, then
//   either clocks read words out on IO1 (unbounded burst, auto-increment) or
//   clocks write words in on IO0, each committed to a synchronous memory port.
//
// Ports
//   clk, rst            system clock, asynchronous active-low reset
//   spi_cs              chip select, active low
//   spi_sclk            serial clock, idle low
//   spi_io0_i           MOSI (command, address, write data)
//   spi_io1_o/_oe       MISO and its output enable
//   mem_addr            memory word address
//   mem_rd_en           read strobe, mem_rdata valid one clk later
//   mem_rdata           memory read data
//   mem_wr_en/mem_wdata single-clk write strobe with its data
//   busy                synchronized CS is low
//   cmd_err             single-clk pulse on an unknown command byte
module spi_mem_responder #(
  parameter int         ADDR_W      = 16,
  parameter int         DATA_W      = 16,
  parameter logic [7:0] CMD_READ    = 8'h03,
  parameter logic [7:0] CMD_WRITE   = 8'h02,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs,
  input  logic              spi_sclk,
  input  logic              spi_io0_i,
  output logic              spi_io1_o,
  output logic              spi_io1_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              cmd_err
);

  localparam int MAXB  = (ADDR_W > DATA_W) ? ((ADDR_W > 8) ? ADDR_W : 8)
                                           : ((DATA_W > 8) ? DATA_W : 8);
  localparam int CNT_W = $clog2(MAXB);

  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  // Rise count (before increment) at which the next word is prefetched.
  localparam logic [CNT_W-1:0] DATA_HALF = CNT_W'(DATA_W / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_RD_FETCH,
    S_RD_LOAD,
    S_RD_DATA,
    S_WR_DATA,
    S_IGNORE
  } state_t;

  state_t state, state_nx;

  // ---------------------------------------------------------------- sync
  // CS synchronizer resets high so busy reads 0 out of reset.
  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, io0_sync;
  logic                   sclk_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      io0_sync  <= '0;
      sclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      io0_sync  <= {io0_sync[SYNC_STAGES-2:0], spi_io0_i};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end
  end

  logic cs_s, sclk_s, mosi, sclk_rise, sclk_fall;
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi      = io0_sync[SYNC_STAGES-1];
  // Edges come from the two newest synced samples; entering with SCLK
  // already high therefore produces no edge until the next rise.
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign busy      = ~cs_s;

  // ------------------------------------------------------------ datapath regs
  logic [CNT_W-1:0]  bit_cnt;
  logic [6:0]        cmd_sr;
  logic              is_wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-2:0] wsr;
  logic              word_done;
  logic              rd_pend;

  logic [7:0]        cmd_byte;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] wr_word;
  logic              cmd_known;

  assign cmd_byte  = {cmd_sr, mosi};
  assign addr_nx   = {addr[ADDR_W-2:0], mosi};
  assign wr_word   = {wsr, mosi};
  assign cmd_known = (cmd_byte == CMD_READ) || (cmd_byte == CMD_WRITE);

  // ---------------------------------------------------------------- fsm
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (!cs_s) state_nx = S_CMD;
      S_CMD:      if (sclk_rise && bit_cnt == CMD_LAST)
                    state_nx = cmd_known ? S_ADDR : S_IGNORE;
      S_ADDR:     if (sclk_rise && bit_cnt == ADDR_LAST)
                    state_nx = is_wr ? S_WR_DATA : S_RD_FETCH;
      S_RD_FETCH: state_nx = S_RD_LOAD;
      S_RD_LOAD:  state_nx = S_RD_DATA;
      default:    ;
    endcase
    // CS release aborts from any state.
    if (cs_s) state_nx = S_IDLE;
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt    <= '0;
      cmd_sr     <= '0;
      is_wr      <= 1'b0;
      addr       <= '0;
      shift      <= '0;
      hold       <= '0;
      wsr        <= '0;
      word_done  <= 1'b0;
      rd_pend    <= 1'b0;
      spi_io1_o  <= 1'b0;
      spi_io1_oe <= 1'b0;
      mem_addr   <= '0;
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_wdata  <= '0;
      cmd_err    <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      cmd_err   <= 1'b0;
      // mem_rdata is valid the clk after a read strobe.
      rd_pend   <= mem_rd_en;

      if (cs_s) begin
        bit_cnt    <= '0;
        word_done  <= 1'b0;
        wsr        <= '0;
        spi_io1_o  <= 1'b0;
        spi_io1_oe <= 1'b0;
      end else begin
        case (state)
          S_CMD: if (sclk_rise) begin
            cmd_sr <= cmd_byte[6:0];
            if (bit_cnt == CMD_LAST) begin
              bit_cnt <= '0;
              is_wr   <= (cmd_byte == CMD_WRITE);
              cmd_err <= ~cmd_known;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end

          S_ADDR: if (sclk_rise) begin
            addr <= addr_nx;
            if (bit_cnt == ADDR_LAST) begin
              bit_cnt <= '0;
              if (!is_wr) begin
                mem_rd_en <= 1'b1;
                mem_addr  <= addr_nx;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end

          // No dummy cycle: the first MSB goes out as soon as data arrives,
          // ahead of the fall that would normally update MISO.
          S_RD_LOAD: begin
            shift      <= mem_rdata;
            spi_io1_oe <= 1'b1;
            spi_io1_o  <= mem_rdata[DATA_W-1];
          end

          S_RD_DATA: begin
            if (rd_pend) hold <= mem_rdata;
            if (sclk_rise) begin
              if (bit_cnt == DATA_LAST) begin
                bit_cnt   <= '0;
                word_done <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == DATA_HALF) begin
                  mem_rd_en <= 1'b1;
                  mem_addr  <= addr + 1'b1;
                  addr      <= addr + 1'b1;
                end
              end
            end
            // The fall between the last rise of the previous phase and the
            // first rise of a word (bit_cnt==0, !word_done) keeps the MSB.
            if (sclk_fall) begin
              if (word_done) begin
                shift     <= hold;
                spi_io1_o <= hold[DATA_W-1];
                word_done <= 1'b0;
              end else if (bit_cnt != '0) begin
                shift     <= shift << 1;
                spi_io1_o <= shift[DATA_W-2];
              end
            end
          end

          S_WR_DATA: if (sclk_rise) begin
            wsr <= wr_word[DATA_W-2:0];
            if (bit_cnt == DATA_LAST) begin
              bit_cnt   <= '0;
              mem_wdata <= wr_word;
              mem_wr_en <= 1'b1;
              mem_addr  <= addr;
              addr      <= addr + 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_responder.sv
// tb_spi_mem_responder
//   Bench for spi_mem_responder: an SPI master model at SCLK = clk/8 drives
//   directed transactions; expected memory strobes, command errors and read
//   words are queued as stimulus is issued and a monitor compares them as the
//   DUT produces them.
module tb_spi_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_cs = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_io0_i = 1'b0;
  logic        spi_io1_o, spi_io1_oe;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_rdata = 16'h0;
  logic        mem_wr_en;
  logic [15:0] mem_wdata;
  logic        busy, cmd_err;

  always #5 clk = ~clk;

  spi_mem_responder dut (
    .clk(clk), .rst(rst), .spi_cs(spi_cs), .spi_sclk(spi_sclk),
    .spi_io0_i(spi_io0_i), .spi_io1_o(spi_io1_o), .spi_io1_oe(spi_io1_oe),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .busy(busy), .cmd_err(cmd_err)
  );

  // synchronous memory, one clk read latency
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
  end

  localparam int EV_RD = 0, EV_WR = 1, EV_ERR = 2;
  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [15:0] data;
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] exp_word_q[$];
  logic [15:0] got_q[$];
  int          n_cmp = 0, n_bad = 0;
  logic        quiet = 1'b0, oe_seen = 1'b0;
  logic        miso_bit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [15:0] a, input logic [15:0] d);
    ev_t e;
    e.kind = kind; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pop_ev(input int kind, input logic [15:0] a, input logic [15:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h expected none", kind, a, d);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_addr", a, e.addr);
      if (kind == EV_WR) chk("ev_wdata", d, e.data);
    end
  endtask

  // monitor
  initial begin
    logic [15:0] g;
    forever begin
      @(negedge clk);
      if (mem_rd_en || mem_wr_en) chk("strobe_excl", mem_rd_en & mem_wr_en, 0);
      if (mem_rd_en) pop_ev(EV_RD, mem_addr, 16'h0);
      if (mem_wr_en) pop_ev(EV_WR, mem_addr, mem_wdata);
      if (cmd_err)   pop_ev(EV_ERR, 16'h0, 16'h0);
      if (quiet && spi_io1_oe) oe_seen = 1'b1;
      while (got_q.size() > 0) begin
        g = got_q.pop_front();
        if (exp_word_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rd_word: got %h expected none", g);
        end else begin
          chk("rd_word", g, exp_word_q.pop_front());
        end
      end
    end
  end

  // master model, SCLK half period = 4 clk
  task automatic xfer(input logic mosi);
    spi_io0_i = mosi;
    repeat (4) @(negedge clk);
    miso_bit = spi_io1_o;
    spi_sclk = 1'b1;
    repeat (4) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  task automatic send(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) xfer(v[i]);
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic start(input logic [7:0] cmd, input logic [15:0] a);
    cs_low();
    send({8'h00, cmd}, 8);
    send(a, 16);
  endtask

  task automatic read_bits(input int n);
    logic [15:0] w;
    w = 16'h0;
    for (int i = 0; i < n; i++) begin
      xfer(1'b0);
      w = {w[14:0], miso_bit};
      if (i % 16 == 15) got_q.push_back(w);
    end
  endtask

  task automatic stop();
    @(negedge clk);
    spi_sclk = 1'b0;
    spi_cs   = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  initial begin
    #500000;
    n_cmp++; n_bad++;
    $display("FAIL timeout: got no end of test expected finish before 500us");
    summary();
    $finish;
  end

  initial begin
    mem[16'h0010] <= 16'hA5C3;
    mem[16'hFFFF] <= 16'h1111;
    mem[16'h0000] <= 16'h2222;
    mem[16'h0001] <= 16'h3333;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {spi_io1_o, spi_io1_oe, mem_rd_en, mem_wr_en, busy, cmd_err}, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_wdata", mem_wdata, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // 1: single word read
    push_ev(EV_RD, 16'h0010, 0); push_ev(EV_RD, 16'h0011, 0);
    exp_word_q.push_back(16'hA5C3);
    start(8'h03, 16'h0010);
    chk("busy_active", busy, 1);
    read_bits(16);
    stop();
    chk("busy_idle", busy, 0);
    chk("oe_after_read", spi_io1_oe, 0);

    // 2: burst across address wrap
    push_ev(EV_RD, 16'hFFFF, 0); push_ev(EV_RD, 16'h0000, 0);
    push_ev(EV_RD, 16'h0001, 0); push_ev(EV_RD, 16'h0002, 0);
    exp_word_q.push_back(16'h1111);
    exp_word_q.push_back(16'h2222);
    exp_word_q.push_back(16'h3333);
    start(8'h03, 16'hFFFF);
    read_bits(48);
    stop();

    // 3: two-word write, then read back the first word
    push_ev(EV_WR, 16'h0200, 16'hBEEF); push_ev(EV_WR, 16'h0201, 16'h1234);
    quiet = 1'b1; oe_seen = 1'b0;
    start(8'h02, 16'h0200);
    send(16'hBEEF, 16);
    send(16'h1234, 16);
    stop();
    quiet = 1'b0;
    chk("wr_oe_low", oe_seen, 0);
    push_ev(EV_RD, 16'h0200, 0); push_ev(EV_RD, 16'h0201, 0);
    exp_word_q.push_back(16'hBEEF);
    start(8'h03, 16'h0200);
    read_bits(16);
    stop();

    // 4: unknown command, ignored until CS high, then normal read
    push_ev(EV_ERR, 0, 0);
    quiet = 1'b1; oe_seen = 1'b0;
    cs_low();
    send(16'h009F, 8);
    send(16'hFFFF, 16);
    stop();
    quiet = 1'b0;
    chk("ign_oe_low", oe_seen, 0);
    push_ev(EV_RD, 16'h0000, 0); push_ev(EV_RD, 16'h0001, 0);
    exp_word_q.push_back(16'h2222);
    start(8'h03, 16'h0000);
    read_bits(16);
    stop();

    // 5: abort mid write word and mid address
    quiet = 1'b1; oe_seen = 1'b0;
    start(8'h02, 16'h0300);
    send(16'h02AF, 10);
    stop();
    cs_low();
    send(16'h0003, 8);
    send(16'h0000, 8);
    stop();
    quiet = 1'b0;
    chk("abort_oe_low", oe_seen, 0);
    chk("abort_busy", busy, 0);
    push_ev(EV_RD, 16'h0010, 0); push_ev(EV_RD, 16'h0011, 0);
    exp_word_q.push_back(16'hA5C3);
    start(8'h03, 16'h0010);
    read_bits(16);
    stop();

    // 6: reset mid burst
    push_ev(EV_RD, 16'h0010, 0); push_ev(EV_RD, 16'h0011, 0);
    exp_word_q.push_back(16'hA5C3);
    start(8'h03, 16'h0010);
    read_bits(20);
    rst = 1'b0;
    #1;
    chk("rst_mid_ctl", {spi_io1_o, spi_io1_oe, mem_rd_en, mem_wr_en, busy, cmd_err}, 0);
    chk("rst_mid_addr", mem_addr, 0);
    chk("rst_mid_wdata", mem_wdata, 0);
    spi_cs = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    push_ev(EV_RD, 16'h0010, 0); push_ev(EV_RD, 16'h0011, 0);
    exp_word_q.push_back(16'hA5C3);
    start(8'h03, 16'h0010);
    read_bits(16);
    stop();

    repeat (10) @(negedge clk);
    chk("events_left", exp_q.size(), 0);
    chk("words_left", exp_word_q.size(), 0);
    summary();
    $finish;
  end

endmodule
